// File: rtl/score_sequencer.sv
// Score sequencer: fetches note entries from a sync ROM, times them in beats, drives the note generator.
// Latency: start -> FETCH next cycle, first note audible 3 cycles after start; every output is registered.
// Backpressure: none; pulse inputs act on the cycle they are sampled (stop > start > pause); SFX overrides music.
module score_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int ADDR_W      = 8,
  parameter int LOOP        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic              score_rd,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [31:0]       score_data,
  input  logic              sfx_req,
  input  logic [21:0]       sfx_div,
  input  logic [3:0]        sfx_beats,
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [2:0]        volume,
  output logic              is_noise,
  output logic              playing,
  output logic              done
);

  localparam int CYC_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int SFX_W = $clog2(15 * BEAT_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BEAT_CYCLES - 1);
  // Last PLAY cycle of the final beat; the next cycle starts the articulation gap.
  localparam logic [CYC_W-1:0] CYC_GAP   = CYC_W'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [SFX_W-1:0] SFX_BEAT  = SFX_W'(BEAT_CYCLES);
  localparam logic [21:0]      DIV_QUIET = 22'd1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_PAUSED} state_t;

  state_t             state, state_nxt, ret_state, ret_nxt;
  logic [ADDR_W-1:0]  addr, addr_nxt;
  logic [CYC_W-1:0]   cyc, cyc_nxt;
  logic [7:0]         beats_left, beats_nxt;
  logic [21:0]        cur_div, div_nxt;
  logic               cur_noise, noise_nxt;
  logic               done_nxt;
  logic [SFX_W-1:0]   sfx_cnt, sfx_cnt_nxt;
  logic [21:0]        sfx_div_q, sfx_div_nxt;
  logic               last_beat;
  logic               music_on;
  logic [21:0]        out_div;
  logic               out_noise;

  assign last_beat = (beats_left == 8'd1);

  // Next-state, beat timing and address sequencing for the music player.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    addr_nxt  = addr;
    cyc_nxt   = cyc;
    beats_nxt = beats_left;
    div_nxt   = cur_div;
    noise_nxt = cur_noise;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE:  addr_nxt  = '0;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        div_nxt   = score_data[21:0];
        noise_nxt = score_data[30];
        beats_nxt = (score_data[29:22] == 8'd0) ? 8'd1 : score_data[29:22];
        cyc_nxt   = '0;
        if (score_data[31]) begin
          addr_nxt = '0;
          if (LOOP != 0) begin
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          state_nxt = S_PLAY;
        end
      end
      S_PLAY, S_GAP: begin
        if (cyc == CYC_LAST) begin
          cyc_nxt   = '0;
          beats_nxt = beats_left - 8'd1;
        end else begin
          cyc_nxt = cyc + 1'b1;
        end
        if (last_beat && cyc == CYC_LAST) begin
          addr_nxt  = addr + 1'b1;
          state_nxt = S_FETCH;
        end else if (state == S_PLAY && last_beat && cyc == CYC_GAP) begin
          state_nxt = S_GAP;
        end
        // The pause cycle itself still counts; resume continues from where timing would have gone.
        if (pause) begin
          ret_nxt   = state_nxt;
          state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: if (pause) state_nxt = ret_state;
      default:  state_nxt = S_IDLE;
    endcase
    if (stop) begin
      state_nxt = S_IDLE;
      addr_nxt  = '0;
      done_nxt  = 1'b0;
    end else if (start) begin
      state_nxt = S_FETCH;
      addr_nxt  = '0;
      done_nxt  = 1'b0;
    end
  end

  // SFX one-shot countdown, independent of the music state and of stop.
  always_comb begin
    sfx_cnt_nxt = sfx_cnt;
    sfx_div_nxt = sfx_div_q;
    if (sfx_req && sfx_beats != 4'd0) begin
      sfx_cnt_nxt = SFX_W'(sfx_beats) * SFX_BEAT;
      sfx_div_nxt = sfx_div;
    end else if (sfx_cnt != '0) begin
      sfx_cnt_nxt = sfx_cnt - 1'b1;
    end
  end

  // Output selection from next-cycle values so every output can be registered.
  always_comb begin
    music_on  = (state_nxt == S_PLAY);
    out_div   = music_on ? div_nxt : DIV_QUIET;
    out_noise = music_on ? noise_nxt : 1'b0;
    if (sfx_cnt_nxt != '0) begin
      out_div   = sfx_div_nxt;
      out_noise = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ret_state      <= S_PLAY;
      addr           <= '0;
      cyc            <= '0;
      beats_left     <= 8'd1;
      cur_div        <= DIV_QUIET;
      cur_noise      <= 1'b0;
      sfx_cnt        <= '0;
      sfx_div_q      <= DIV_QUIET;
      score_rd       <= 1'b0;
      score_addr     <= '0;
      note_div_left  <= DIV_QUIET;
      note_div_right <= DIV_QUIET;
      is_noise       <= 1'b0;
      playing        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      ret_state      <= ret_nxt;
      addr           <= addr_nxt;
      cyc            <= cyc_nxt;
      beats_left     <= beats_nxt;
      cur_div        <= div_nxt;
      cur_noise      <= noise_nxt;
      sfx_cnt        <= sfx_cnt_nxt;
      sfx_div_q      <= sfx_div_nxt;
      score_rd       <= (state_nxt == S_FETCH);
      score_addr     <= addr_nxt;
      note_div_left  <= out_div;
      note_div_right <= out_div;
      is_noise       <= out_noise;
      playing        <= (state_nxt != S_IDLE);
      done           <= done_nxt;
    end
  end

  // Saturating volume, 1..5; simultaneous up and down cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      volume <= 3'd3;
    end else if (vol_up && !vol_down && volume != 3'd5) begin
      volume <= volume + 3'd1;
    end else if (vol_down && !vol_up && volume != 3'd1) begin
      volume <= volume - 3'd1;
    end
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: two instances (LOOP=0 and LOOP=1) share stimulus and a ROM image.
// A note-level reference model (remaining cycles per note) predicts every output each cycle.
// Directed scenarios pin the documented timings; a randomized run covers interactions.
module tb_score_sequencer;
  localparam int BEAT = 10;
  localparam int GAP  = 2;
  localparam int AW   = 4;
  localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_NOTE = 3, M_PAUSED = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, vol_up = 1'b0, vol_down = 1'b0;
  logic sfx_req = 1'b0;
  logic [21:0] sfx_div = 22'd0;
  logic [3:0]  sfx_beats = 4'd0;
  logic          rd [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   data [2];
  logic [21:0]   div_l [2], div_r [2];
  logic [2:0]    vol [2];
  logic          noise [2], playing [2], done [2];
  logic [31:0]   rom [16];

  always @(posedge clk)
    for (int i = 0; i < 2; i++) if (rd[i]) data[i] <= rom[addr[i]];

  score_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .vol_up(vol_up),
    .vol_down(vol_down), .score_rd(rd[0]), .score_addr(addr[0]), .score_data(data[0]),
    .sfx_req(sfx_req), .sfx_div(sfx_div), .sfx_beats(sfx_beats), .note_div_left(div_l[0]),
    .note_div_right(div_r[0]), .volume(vol[0]), .is_noise(noise[0]), .playing(playing[0]),
    .done(done[0]));

  score_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .vol_up(vol_up),
    .vol_down(vol_down), .score_rd(rd[1]), .score_addr(addr[1]), .score_data(data[1]),
    .sfx_req(sfx_req), .sfx_div(sfx_div), .sfx_beats(sfx_beats), .note_div_left(div_l[1]),
    .note_div_right(div_r[1]), .volume(vol[1]), .is_noise(noise[1]), .playing(playing[1]),
    .done(done[1]));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one note is a countdown of beats*BEAT cycles, audible while more than GAP remain.
  int m_mode [2], m_saved [2], m_addr [2], m_rem [2], m_div [2], m_noise [2], m_done [2];
  int m_sfx_rem = 0, m_sfx_div = 1, m_vol = 3;

  task automatic model_step();
    logic [31:0] e;
    int nb, nxt;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (rst || stop) begin
        m_mode[i] = M_IDLE; m_addr[i] = 0;
      end else if (start) begin
        m_mode[i] = M_FETCH; m_addr[i] = 0;
      end else begin
        case (m_mode[i])
          M_FETCH: m_mode[i] = M_LOAD;
          M_LOAD: begin
            e = rom[m_addr[i]];
            if (e[31]) begin
              m_addr[i] = 0;
              if (i == 1) m_mode[i] = M_FETCH;
              else begin m_mode[i] = M_IDLE; m_done[i] = 1; end
            end else begin
              nb = int'(e[29:22]);
              if (nb == 0) nb = 1;
              m_div[i] = int'(e[21:0]); m_noise[i] = int'(e[30]);
              m_rem[i] = nb * BEAT; m_mode[i] = M_NOTE;
            end
          end
          M_NOTE: begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin m_addr[i] = (m_addr[i] + 1) % 16; nxt = M_FETCH; end
            else nxt = M_NOTE;
            if (pause) begin m_saved[i] = nxt; m_mode[i] = M_PAUSED; end
            else m_mode[i] = nxt;
          end
          M_PAUSED: if (pause) m_mode[i] = m_saved[i];
          default: ;
        endcase
      end
    end
    if (rst) begin
      m_sfx_rem = 0; m_vol = 3;
    end else begin
      if (sfx_req && sfx_beats != 0) begin m_sfx_rem = int'(sfx_beats) * BEAT; m_sfx_div = int'(sfx_div); end
      else if (m_sfx_rem > 0) m_sfx_rem--;
      if (vol_up && !vol_down && m_vol < 5) m_vol++;
      else if (vol_down && !vol_up && m_vol > 1) m_vol--;
    end
  endtask

  // Event logs for the directed scenarios (cycle numbers counted from the start pulse).
  int cyc_no = 0, trk_div = 100;
  int hit_q [2][$];
  int done_q [2][$];
  int rd_q0 [$];

  function automatic int qat(input int q[$], input int idx);
    return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic trk_clear(input int d);
    cyc_no = 0; trk_div = d; rd_q0.delete();
    for (int i = 0; i < 2; i++) begin hit_q[i].delete(); done_q[i].delete(); end
  endtask

  task automatic cyc_go();
    int ed, en;
    @(posedge clk);
    model_step();
    #1;
    cyc_no++;
    for (int i = 0; i < 2; i++) begin
      ed = (m_sfx_rem > 0) ? m_sfx_div : (m_mode[i] == M_NOTE && m_rem[i] > GAP) ? m_div[i] : 1;
      en = (m_sfx_rem == 0 && m_mode[i] == M_NOTE && m_rem[i] > GAP) ? m_noise[i] : 0;
      chk($sformatf("div_left%0d", i), div_l[i], ed);
      chk($sformatf("div_right%0d", i), div_r[i], ed);
      chk($sformatf("noise%0d", i), noise[i], en);
      chk($sformatf("volume%0d", i), vol[i], m_vol);
      chk($sformatf("score_rd%0d", i), rd[i], (m_mode[i] == M_FETCH) ? 1 : 0);
      chk($sformatf("score_addr%0d", i), addr[i], m_addr[i]);
      chk($sformatf("playing%0d", i), playing[i], (m_mode[i] != M_IDLE) ? 1 : 0);
      chk($sformatf("done%0d", i), done[i], m_done[i]);
      if (div_l[i] == trk_div[21:0]) hit_q[i].push_back(cyc_no);
      if (done[i]) done_q[i].push_back(cyc_no);
    end
    if (rd[0]) rd_q0.push_back(cyc_no);
    rst = 0; start = 0; stop = 0; pause = 0; vol_up = 0; vol_down = 0; sfx_req = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc_no < c) cyc_go();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_go();
  endtask

  function automatic logic [31:0] rand_entry();
    logic [31:0] e;
    e[21:0]  = 22'($urandom_range(1, 4000));
    e[29:22] = 8'($urandom_range(0, 3));
    e[30]    = 1'($urandom_range(0, 1));
    e[31]    = ($urandom_range(0, 5) == 0);
    return e;
  endfunction

  int exp_up [4]   = '{4, 5, 5, 5};
  int exp_down [6] = '{4, 3, 2, 1, 1, 1};

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = 32'h8000_0000;
    rom[0] = {1'b0, 1'b0, 8'd2, 22'd100};
    for (int i = 0; i < 2; i++) begin m_mode[i] = M_IDLE; m_addr[i] = 0; m_rem[i] = 0; m_saved[i] = M_NOTE; end

    // Reset values
    do_reset();
    chk("rst_div", div_l[0], 1); chk("rst_vol", vol[0], 3); chk("rst_playing", playing[0], 0);

    // Single note then end marker, both LOOP settings
    trk_clear(100); start = 1; cyc_go(); run_to(35);
    chk("t1_first_rd", qat(rd_q0, 0), 1);
    chk("t1_first_note", qat(hit_q[0], 0), 3);
    chk("t1_last_note", qat(hit_q[0], 17), 20);
    chk("t1_note_len", hit_q[0].size(), 18);
    chk("t1_second_rd", qat(rd_q0, 1), 23);
    chk("t1_done_at", qat(done_q[0], 0), 25);
    chk("t1_done_cnt", done_q[0].size(), 1);
    chk("t2_loop_restart", qat(hit_q[1], 18), 27);
    chk("t2_no_done", done_q[1].size(), 0);

    // Pause mid-note for 50 cycles
    do_reset(); trk_clear(100); start = 1; cyc_go(); run_to(8);
    pause = 1; cyc_go(); run_to(58);
    pause = 1; cyc_go(); run_to(90);
    chk("t3_note_len", hit_q[0].size(), 18);
    chk("t3_resume_at", qat(hit_q[0], 6), 59);
    chk("t3_done_at", qat(done_q[0], 0), 75);

    // SFX during PLAY
    do_reset(); trk_clear(500); start = 1; cyc_go(); run_to(5);
    sfx_req = 1; sfx_div = 22'd500; sfx_beats = 4'd1; cyc_go(); run_to(35);
    chk("t4_sfx_first", qat(hit_q[0], 0), 6);
    chk("t4_sfx_len", hit_q[0].size(), 10);
    chk("t4_done_at", qat(done_q[0], 0), 25);

    // Volume saturation
    do_reset();
    for (int k = 0; k < 4; k++) begin vol_up = 1; cyc_go(); chk("t5_vol_up", vol[0], exp_up[k]); end
    for (int k = 0; k < 6; k++) begin vol_down = 1; cyc_go(); chk("t5_vol_down", vol[0], exp_down[k]); end
    vol_up = 1; vol_down = 1; cyc_go(); chk("t5_vol_both", vol[0], 1);

    // stop+start together during PLAY, then reset during GAP
    do_reset(); trk_clear(100); start = 1; cyc_go(); run_to(10);
    stop = 1; start = 1; cyc_go();
    chk("t6_stop_playing", playing[0], 0); chk("t6_stop_div", div_l[0], 1);
    chk("t6_stop_rd", rd[0], 0); chk("t6_stop_done", done[0], 0);
    trk_clear(100); start = 1; vol_up = 1; cyc_go(); run_to(21);
    chk("t6_in_gap_div", div_l[0], 1); chk("t6_in_gap_playing", playing[0], 1);
    rst = 1; cyc_go();
    chk("t6_rst_div", div_l[0], 1); chk("t6_rst_vol", vol[0], 3);
    chk("t6_rst_playing", playing[0], 0); chk("t6_rst_addr", addr[0], 0);

    // Address wrap: sixteen one-beat notes without an end marker
    for (int a = 0; a < 16; a++) rom[a] = {1'b0, 1'b0, 8'd1, 22'(200 + a)};
    do_reset(); trk_clear(215); start = 1; cyc_go(); run_to(16 * 14 + 20);
    chk("wrap_last_note_seen", hit_q[1].size() > 0, 1);

    // Randomized interaction
    for (int a = 0; a < 16; a++) rom[a] = rand_entry();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 59) == 0);
      stop     = ($urandom_range(0, 149) == 0);
      pause    = ($urandom_range(0, 39) == 0);
      vol_up   = ($urandom_range(0, 9) == 0);
      vol_down = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 79) == 0) begin
        sfx_req = 1; sfx_div = 22'($urandom_range(2, 9000)); sfx_beats = 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc_go();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
